// File: rtl/run_sequencer.sv
// Game-flow controller for the BCD score counter: IDLE/CLEAR/RUN/DEAD sequencing,
// prescaled score ticks, high-score capture and score-derived speed level.
module run_sequencer #(
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned DEAD_HOLD = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       collision,
    input  logic [3:0] score3,
    input  logic [3:0] score2,
    input  logic [3:0] score1,
    input  logic [3:0] score0,
    output logic       alive,
    output logic       counter_clr,
    output logic       score_tick,
    output logic [1:0] state,
    output logic [3:0] hi3,
    output logic [3:0] hi2,
    output logic [3:0] hi1,
    output logic [3:0] hi0,
    output logic       new_hi,
    output logic [1:0] level
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned HW = $clog2(DEAD_HOLD + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(DEAD_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DEAD  = 2'd3
    } state_t;

    state_t          state_q;
    logic            start_q;
    logic [PW-1:0]   presc_q;
    logic [HW-1:0]   hold_q;
    logic [15:0]     hi_q;
    logic            alive_q;
    logic            clr_q;
    logic            tick_q;
    logic            new_hi_q;
    logic [1:0]      level_q;

    logic [15:0]     score_w;
    logic            start_edge;
    logic            presc_wrap;
    logic [PW-1:0]   presc_d;
    logic [HW-1:0]   hold_d;
    logic [1:0]      level_d;

    assign score_w = {score3, score2, score1, score0};

    // BCD digits compare correctly as plain hex, so thresholds are BCD literals.
    always_comb begin
        start_edge = start_btn & ~start_q;
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        hold_d     = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        if (score_w < 16'h0040) begin
            level_d = 2'd0;
        end else if (score_w < 16'h0100) begin
            level_d = 2'd1;
        end else if (score_w < 16'h0200) begin
            level_d = 2'd2;
        end else begin
            level_d = 2'd3;
        end
    end

    // The CLEAR->RUN edge already counts as one prescaler step, so the tick
    // registered from presc_q==TICK_DIV-1 lands on RUN cycle TICK_DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            presc_q  <= '0;
            hold_q   <= '0;
            hi_q     <= '0;
            alive_q  <= 1'b0;
            clr_q    <= 1'b0;
            tick_q   <= 1'b0;
            new_hi_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            start_q <= start_btn;
            clr_q   <= 1'b0;
            tick_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_q  <= CLEAR;
                        clr_q    <= 1'b1;
                        presc_q  <= '0;
                        hold_q   <= '0;
                        level_q  <= 2'd0;
                        new_hi_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    state_q <= RUN;
                    alive_q <= 1'b1;
                    presc_q <= presc_d;
                end
                RUN: begin
                    level_q <= level_d;
                    if (collision) begin
                        state_q <= DEAD;
                        alive_q <= 1'b0;
                    end else begin
                        presc_q <= presc_d;
                        tick_q  <= presc_wrap;
                    end
                end
                DEAD: begin
                    if (hold_q == '0 && score_w > hi_q) begin
                        hi_q     <= score_w;
                        new_hi_q <= 1'b1;
                    end
                    if (start_edge && hold_q == HOLD_MAX) begin
                        state_q  <= CLEAR;
                        clr_q    <= 1'b1;
                        presc_q  <= '0;
                        hold_q   <= '0;
                        level_q  <= 2'd0;
                        new_hi_q <= 1'b0;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state       = state_q;
    assign alive       = alive_q;
    assign counter_clr = clr_q;
    assign score_tick  = tick_q;
    assign new_hi      = new_hi_q;
    assign level       = level_q;
    assign hi3         = hi_q[15:12];
    assign hi2         = hi_q[11:8];
    assign hi1         = hi_q[7:4];
    assign hi0         = hi_q[3:0];

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Game-flow controller that sequences the BCD score counter.
- Owns the IDLE/CLEAR/RUN/DEAD state machine and produces the counter's `alive` qualifier, a clear pulse and a prescaled score-tick enable.
- Tracks the 4-digit BCD high score and derives the 2-bit speed level for the obstacle/scroll logic.
- Sits between the button/collision logic and the score counter.

Parameters:
- TICK_DIV, 5000000, clk cycles per score increment; must be ≥2.
- DEAD_HOLD, 100000000, minimum clk cycles in DEAD before a restart is accepted; must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- start_btn  input  1  start/restart button level; already synchronized to clk
- collision  input  1  level; player hit an obstacle
- score3..score0  input  4 each  current BCD score digits from the counter (score3 = MSD)
- alive  output  1  high only in RUN
- counter_clr  output  1  one-cycle pulse clearing the score counter
- score_tick  output  1  one-cycle count-enable pulse to the counter
- state  output  2  0=IDLE, 1=CLEAR, 2=RUN, 3=DEAD
- hi3..hi0  output  4 each  high-score BCD digits
- new_hi  output  1  last finished run set a new high score
- level  output  2  speed level

Behaviour:
- **Reset (async):**
  - state=IDLE.
  - alive, counter_clr, score_tick, new_hi = 0.
  - level = 0.
  - hi = 0000.
  - Prescaler, hold timer and start_q = 0.
  - Reset mid-run aborts immediately. The high score is also lost.
- **Start edge:** start_q is start_btn registered; start_edge = start_btn & ~start_q. Held buttons produce one edge only.
- **IDLE:** start_edge → CLEAR. Collision is ignored.
- **CLEAR (exactly 1 cycle):**
  - counter_clr=1.
  - Prescaler and hold timer cleared; level=0; new_hi=0.
  - Next state is RUN unconditionally.
- **RUN:**
  - alive=1.
  - Prescaler counts 0..TICK_DIV-1 and wraps. score_tick=1 in the cycle the prescaler equals TICK_DIV-1, so the first tick comes TICK_DIV cycles after RUN entry.
  - collision=1 → DEAD next cycle. A tick due in that same cycle is suppressed (score_tick=0).
  - start_edge in RUN is ignored.
- **DEAD:**
  - alive=0, score_tick=0, and the prescaler holds its value.
  - On the first DEAD cycle, the score inputs are compared to hi as a 16-bit unsigned value. BCD ordering equals binary ordering.
    - If score > hi: hi latches score and new_hi=1.
    - Equal does not update.
  - The hold timer increments from 0 while in DEAD and saturates at DEAD_HOLD.
    - start_edge while timer < DEAD_HOLD is ignored.
    - start_edge once timer == DEAD_HOLD → CLEAR.
- **Level:**
  - Registered, updated every RUN cycle from the score inputs:
    - 0: score < 0040
    - 1: 0040–0099
    - 2: 0100–0199
    - 3: ≥ 0200
  - Frozen in DEAD and IDLE; zeroed in CLEAR.
- **Registered outputs:** all outputs are registered. alive, state and the other outputs change on the clk edge that enters the state.
- **Counter wrap:** score wrapping 9999→0000 is not detected; level follows the wrapped value.

Test Plan (TICK_DIV=4, DEAD_HOLD=8):
1. **Reset and start.**
   - Stimulus: assert rst, release, pulse start_btn.
   - Required:
     - All outputs 0 and state=0 after reset.
     - One cycle with state=1 and counter_clr=1.
     - Then state=2 and alive=1.
     - First score_tick on the 4th RUN cycle, then every 4 cycles.
2. **Collision coincident with a tick.**
   - Stimulus: assert collision in the cycle the prescaler equals 3.
   - Required: no score_tick; state=3 and alive=0 next cycle.
3. **High-score update.**
   - Stimulus: hold score inputs at 0123 and collide (hi=0000).
   - Required:
     - hi=0123 and new_hi=1.
     - Second run dying at 0050: hi stays 0123, new_hi=0.
     - Dying at exactly 0123: no update.
4. **Dead-hold lockout.**
   - Stimulus: pulse start 3 cycles after entering DEAD; pulse again after 10 cycles.
   - Required: first pulse ignored (state stays 3); second pulse gives CLEAR then RUN.
5. **Level boundaries.**
   - Stimulus: drive score 0039, 0040, 0099, 0100, 0200 during RUN.
   - Required: level 0, 1, 1, 2, 3 respectively, one cycle after each change. Level frozen after collision; 0 after CLEAR.
6. **Async reset mid-RUN.**
   - Stimulus: assert rst mid-RUN with hi=0123.
   - Required: outputs and hi are 0 immediately, without waiting for a clk edge. Held start_btn after release gives exactly one start.
